// File: rtl/refill_pkg.sv
// Shared definitions for the cache refill arbiter: FSM state encoding,
// default burst length and the helper that sizes the beat counter.
package refill_pkg;

    // Arbiter sequencing: wait for a request, run the beats, pulse done.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Words per cache-line refill when the instantiation does not override it.
    localparam int DEFAULT_BEATS = 4;

    // Width of the beat index; never narrower than one bit.
    function automatic int beat_w(input int beats);
        return (beats < 2) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/refill_perf.sv
// Performance counters for the refill arbiter: grants per side and cycles
// during which the pipeline was asked to stall. All counters saturate.
// Only instantiated when REFILL_ARB_PERF_EN is defined.
module refill_perf
    import refill_pkg::*;
(
    input  logic        realClock,
    input  logic        reset,
    input  logic        i_grantI,
    input  logic        i_grantD,
    input  logic        i_stall,
    output logic [31:0] o_iMissCount,
    output logic [31:0] o_dMissCount,
    output logic [31:0] o_stallCycles
);

    logic [31:0] r_iMiss;
    logic [31:0] r_dMiss;
    logic [31:0] r_stall;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // Count I grants, D grants and stalled cycles on every rising edge.
    always_ff @(posedge realClock or posedge reset) begin
        if (reset) begin
            r_iMiss <= 32'd0;
            r_dMiss <= 32'd0;
            r_stall <= 32'd0;
        end else begin
            if (i_grantI) begin
                r_iMiss <= sat_inc(r_iMiss);
            end
            if (i_grantD) begin
                r_dMiss <= sat_inc(r_dMiss);
            end
            if (i_stall) begin
                r_stall <= sat_inc(r_stall);
            end
        end
    end

    assign o_iMissCount  = r_iMiss;
    assign o_dMissCount  = r_dMiss;
    assign o_stallCycles = r_stall;

endmodule

// File: rtl/refill_arbiter.sv
// Refill arbiter: shares one backing-memory port between the I-cache refill
// path and the D-cache refill / single-word write path. Round-robin on ties,
// one burst at a time, one-cycle done pulse back to the owner.
// Optional performance counters are enabled with REFILL_ARB_PERF_EN.
module refill_arbiter
    import refill_pkg::*;
#(
    parameter int BEATS  = DEFAULT_BEATS,
    parameter int ADDR_W = 32
) (
    input  logic                       realClock,
    input  logic                       reset,
    input  logic                       iReq,
    input  logic [ADDR_W-1:0]          iAddr,
    input  logic                       dReq,
    input  logic                       dWr,
    input  logic [ADDR_W-1:0]          dAddr,
    input  logic [31:0]                dWdata,
    output logic                       memReq,
    output logic                       memWr,
    output logic [ADDR_W-1:0]          memAddr,
    output logic [31:0]                memWdata,
    input  logic                       memAck,
    input  logic [31:0]                memRdata,
    output logic                       fillValid,
    output logic                       fillToI,
    output logic [beat_w(BEATS)-1:0]   fillWord,
    output logic [31:0]                fillData,
    output logic                       iDone,
    output logic                       dDone,
    output logic                       outStall
`ifdef REFILL_ARB_PERF_EN
    ,
    output logic [31:0]                iMissCount,
    output logic [31:0]                dMissCount,
    output logic [31:0]                stallCycles
`endif
);

    localparam int BW    = beat_w(BEATS);
    localparam int OFF_W = BW + 2;

    // Clears the byte offset within a cache line.
    localparam logic [ADDR_W-1:0] LINE_MASK =
        ~((ADDR_W'(1) << OFF_W) - ADDR_W'(1));
    // Clears the byte offset within a word.
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);
    localparam logic [BW-1:0]     LAST_BEAT = BW'(BEATS - 1);
    localparam logic [ADDR_W-1:0] WORD_STEP = ADDR_W'(4);

    state_t              r_state;
    logic [BW-1:0]       r_beat;
    logic                r_lastD;     // 1 when the most recent grant went to D
    logic                r_ownI;      // owner of the burst in flight
    logic                r_memReq;
    logic                r_memWr;     // doubles as "this burst is a write"
    logic [ADDR_W-1:0]   r_memAddr;
    logic [31:0]         r_memWdata;
    logic                r_iDone;
    logic                r_dDone;

    logic                w_anyReq;
    logic                w_grantI;
    logic                w_grant;
    logic                w_dWrite;
    logic                w_beatAck;
    logic                w_lastBeat;
    logic [ADDR_W-1:0]   w_grantAddr;

    function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] a);
        return a & LINE_MASK;
    endfunction

    function automatic logic [ADDR_W-1:0] word_base(input logic [ADDR_W-1:0] a);
        return a & WORD_MASK;
    endfunction

    // Arbitration: a lone requester wins; on a tie the side that did not
    // win last time gets the port.
    always_comb begin
        w_anyReq    = iReq | dReq;
        w_grantI    = iReq & (~dReq | r_lastD);
        w_grant     = (r_state == ST_IDLE) & w_anyReq;
        w_dWrite    = ~w_grantI & dWr;
        w_grantAddr = w_grantI ? line_base(iAddr)
                    : (dWr ? word_base(dAddr) : line_base(dAddr));
    end

    // Beat bookkeeping: an acknowledge only counts while a request is out,
    // and a write burst is always a single beat.
    always_comb begin
        w_beatAck  = r_memReq & memAck;
        w_lastBeat = r_memWr | (r_beat == LAST_BEAT);
    end

    // Main sequencer: grant, issue beats until the line (or write) is done,
    // then hold one cycle in DONE to pulse the owner's completion.
    always_ff @(posedge realClock or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_beat     <= '0;
            r_lastD    <= 1'b1;
            r_ownI     <= 1'b0;
            r_memReq   <= 1'b0;
            r_memWr    <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= 32'd0;
            r_iDone    <= 1'b0;
            r_dDone    <= 1'b0;
        end else begin
            r_iDone <= 1'b0;
            r_dDone <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state    <= ST_BURST;
                        r_ownI     <= w_grantI;
                        r_lastD    <= ~w_grantI;
                        r_beat     <= '0;
                        r_memReq   <= 1'b1;
                        r_memWr    <= w_dWrite;
                        r_memAddr  <= w_grantAddr;
                        r_memWdata <= w_dWrite ? dWdata : 32'd0;
                    end
                end
                ST_BURST: begin
                    if (w_beatAck) begin
                        if (w_lastBeat) begin
                            r_state  <= ST_DONE;
                            r_memReq <= 1'b0;
                            r_memWr  <= 1'b0;
                            r_beat   <= '0;
                            r_iDone  <= r_ownI;
                            r_dDone  <= ~r_ownI;
                        end else begin
                            r_beat    <= r_beat + BW'(1);
                            r_memAddr <= r_memAddr + WORD_STEP;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_memReq <= 1'b0;
                    r_memWr  <= 1'b0;
                end
            endcase
        end
    end

    // Fill beats go straight through in the acknowledge cycle; outside a
    // read beat the fill bus is held at zero.
    always_comb begin
        fillValid = w_beatAck & ~r_memWr;
        fillToI   = fillValid & r_ownI;
        fillWord  = fillValid ? r_beat : '0;
        fillData  = fillValid ? memRdata : 32'd0;
    end

    assign memReq   = r_memReq;
    assign memWr    = r_memWr;
    assign memAddr  = r_memAddr;
    assign memWdata = r_memWdata;
    assign iDone    = r_iDone;
    assign dDone    = r_dDone;
    assign outStall = w_anyReq | (r_state != ST_IDLE);

`ifdef REFILL_ARB_PERF_EN
    logic w_grantEvtI;
    logic w_grantEvtD;

    assign w_grantEvtI = w_grant & w_grantI;
    assign w_grantEvtD = w_grant & ~w_grantI;

    refill_perf u_perf (
        .realClock     (realClock),
        .reset         (reset),
        .i_grantI      (w_grantEvtI),
        .i_grantD      (w_grantEvtD),
        .i_stall       (outStall),
        .o_iMissCount  (iMissCount),
        .o_dMissCount  (dMissCount),
        .o_stallCycles (stallCycles)
    );
`endif

endmodule
